// File: rtl/mips_hazard_scoreboard.sv
// mips_hazard_scoreboard
//   Hazard and forwarding scoreboard for the pipelined MIPS core. Keeps one
//   destination record per stage after ID (entry 0 = EXE ... DEPTH-1 = WB),
//   each with a result-ready countdown. For every source operand of the
//   instruction in ID it picks a forwarding source or requests a stall.
// Ports
//   clk, rst        core clock, synchronous active-high reset
//   forward_en      1 = forwarding allowed, 0 = every RAW match stalls
//   issue_*         instruction in ID (valid, sources, source-used mask,
//                   destination, write enable, result latency)
//   kill            per-entry invalidate, takes effect at the next edge
//   stall           hold IF/ID and insert a bubble
//   fwd_sel         per source: 0 = register file, k+1 = entry k result bus
//   issue_accept    issue_valid & ~stall
//   stall_cnt       saturating count of stalled cycles

// Per-source resolver: the youngest matching entry decides the outcome.
module mips_hazard_src_resolve #(
  parameter int DEPTH        = 3,
  parameter int REG_ADDR_LEN = 5,
  parameter int LAT_W        = 3,
  parameter int SEL_W        = 2
) (
  input  logic                                used,
  input  logic [REG_ADDR_LEN-1:0]             src,
  input  logic                                forward_en,
  input  logic [DEPTH-1:0]                    ent_live,
  input  logic [DEPTH-1:0][REG_ADDR_LEN-1:0]  ent_dest,
  input  logic [DEPTH-1:0][LAT_W-1:0]         ent_cnt,
  output logic [SEL_W-1:0]                    sel,
  output logic                                hazard
);
  logic found;

  always_comb begin
    sel    = '0;
    hazard = 1'b0;
    found  = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!found && used && (src != '0) && ent_live[k] && (ent_dest[k] == src)) begin
        found = 1'b1;
        if (forward_en && (ent_cnt[k] == '0)) sel    = SEL_W'(k + 1);
        else                                  hazard = 1'b1;
      end
    end
  end
endmodule

module mips_hazard_scoreboard #(
  parameter int DEPTH        = 3,
  parameter int REG_ADDR_LEN = 5,
  parameter int NUM_SRC      = 2,
  parameter int LAT_W        = 3,
  parameter int SEL_W        = $clog2(DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             forward_en,
  input  logic                             issue_valid,
  input  logic [NUM_SRC*REG_ADDR_LEN-1:0]  issue_src,
  input  logic [NUM_SRC-1:0]               issue_src_used,
  input  logic [REG_ADDR_LEN-1:0]          issue_dest,
  input  logic                             issue_wb_en,
  input  logic [LAT_W-1:0]                 issue_lat,
  input  logic [DEPTH-1:0]                 kill,
  output logic                             stall,
  output logic [NUM_SRC*SEL_W-1:0]         fwd_sel,
  output logic                             issue_accept,
  output logic [31:0]                      stall_cnt
);
  typedef struct packed {
    logic                    valid;
    logic                    wb_en;
    logic [REG_ADDR_LEN-1:0] dest;
    logic [LAT_W-1:0]        cnt;
  } entry_t;

  entry_t [DEPTH-1:0]                   ent_q;
  entry_t                               new_ent;
  logic   [DEPTH-1:0]                   ent_live;
  logic   [DEPTH-1:0][REG_ADDR_LEN-1:0] ent_dest;
  logic   [DEPTH-1:0][LAT_W-1:0]        ent_cnt;
  logic   [NUM_SRC-1:0]                 hazard;
  logic   [LAT_W-1:0]                   lat_load;
  logic   [31:0]                        stall_cnt_q;
  logic                                 unused_kill;

  // The retiring entry has no successor, so its kill bit has nothing to clear.
  assign unused_kill = kill[DEPTH-1];

  for (genvar k = 0; k < DEPTH; k++) begin : g_flat
    assign ent_live[k] = ent_q[k].valid & ent_q[k].wb_en;
    assign ent_dest[k] = ent_q[k].dest;
    assign ent_cnt[k]  = ent_q[k].cnt;
  end

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    mips_hazard_src_resolve #(
      .DEPTH(DEPTH), .REG_ADDR_LEN(REG_ADDR_LEN), .LAT_W(LAT_W), .SEL_W(SEL_W)
    ) u_res (
      .used       (issue_src_used[s]),
      .src        (issue_src[s*REG_ADDR_LEN +: REG_ADDR_LEN]),
      .forward_en (forward_en),
      .ent_live   (ent_live),
      .ent_dest   (ent_dest),
      .ent_cnt    (ent_cnt),
      .sel        (fwd_sel[s*SEL_W +: SEL_W]),
      .hazard     (hazard[s])
    );
  end

  assign stall        = issue_valid & (|hazard);
  assign issue_accept = issue_valid & ~stall;
  assign stall_cnt    = stall_cnt_q;

  // Entering entry 0 counts as the first move, so a latency-1 producer is
  // forwardable from EXE on the very next cycle. A latency that cannot expire
  // before WB is stored unreduced so it stays non-zero through retirement;
  // consumers then wait and read the register file.
  always_comb begin
    lat_load = issue_lat;
    if (int'(issue_lat) <= DEPTH - 1 && issue_lat != '0) lat_load = issue_lat - 1'b1;
  end

  always_comb begin
    new_ent       = '0;
    new_ent.valid = issue_accept;
    if (issue_accept) begin
      new_ent.wb_en = issue_wb_en;
      new_ent.dest  = issue_dest;
      new_ent.cnt   = lat_load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      ent_q[0] <= new_ent;
      for (int k = 0; k < DEPTH - 1; k++) begin
        ent_q[k+1].valid <= ent_q[k].valid & ~kill[k];
        ent_q[k+1].wb_en <= ent_q[k].wb_en;
        ent_q[k+1].dest  <= ent_q[k].dest;
        ent_q[k+1].cnt   <= (ent_q[k].cnt == '0) ? '0 : ent_q[k].cnt - 1'b1;
      end
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_mips_hazard_scoreboard.sv
module tb_mips_hazard_scoreboard;
  logic        clk = 1'b0;
  logic        rst;
  logic        forward_en;
  logic        issue_valid;
  logic [9:0]  issue_src;
  logic [1:0]  issue_src_used;
  logic [4:0]  issue_dest;
  logic        issue_wb_en;
  logic [2:0]  issue_lat;
  logic [2:0]  kill;
  logic        stall;
  logic [3:0]  fwd_sel;
  logic        issue_accept;
  logic [31:0] stall_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mips_hazard_scoreboard dut (
    .clk(clk), .rst(rst), .forward_en(forward_en), .issue_valid(issue_valid),
    .issue_src(issue_src), .issue_src_used(issue_src_used), .issue_dest(issue_dest),
    .issue_wb_en(issue_wb_en), .issue_lat(issue_lat), .kill(kill),
    .stall(stall), .fwd_sel(fwd_sel), .issue_accept(issue_accept), .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive an ID-stage instruction and let combinational outputs settle.
  task automatic drive(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                       input logic [1:0] used, input logic [4:0] d, input logic wb,
                       input logic [2:0] lat);
    issue_valid = v; issue_src = {s1, s0}; issue_src_used = used;
    issue_dest = d; issue_wb_en = wb; issue_lat = lat;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 3'd0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic flush();
    idle();
    repeat (3) tick();
  endtask

  initial begin
    rst = 1'b1; forward_en = 1'b1; kill = '0;
    idle();
    repeat (2) tick();
    rst = 1'b0;

    // Reset state
    drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 3'd1);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_fwd", 32'(fwd_sel), 32'd0);
    check("rst_accept", 32'(issue_accept), 32'd1);
    check("rst_cnt", stall_cnt, 32'd0);
    idle();

    // Back-to-back ALU dependency
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 3'd1); tick();
    drive(1'b1, 5'd3, 5'd0, 2'b01, 5'd4, 1'b1, 3'd1);
    check("alu_stall", 32'(stall), 32'd0);
    check("alu_fwd", 32'(fwd_sel), 32'h1);
    check("alu_accept", 32'(issue_accept), 32'd1);
    tick(); flush();

    // Load-use
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 3'd2); tick();
    drive(1'b1, 5'd5, 5'd0, 2'b01, 5'd6, 1'b1, 3'd1);
    check("ld_stall1", 32'(stall), 32'd1);
    check("ld_fwd1", 32'(fwd_sel), 32'd0);
    check("ld_acc1", 32'(issue_accept), 32'd0);
    tick();
    check("ld_stall2", 32'(stall), 32'd0);
    check("ld_fwd2", 32'(fwd_sel), 32'h2);
    check("ld_cnt", stall_cnt, 32'd1);
    tick(); flush();

    // Forwarding disabled: stall while producer occupies entries 0..2
    forward_en = 1'b0;
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 3'd1); tick();
    drive(1'b1, 5'd0, 5'd7, 2'b10, 5'd8, 1'b1, 3'd1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("nofwd_stall%0d", i), 32'(stall), 32'd1);
      tick();
    end
    check("nofwd_stall3", 32'(stall), 32'd0);
    check("nofwd_fwd", 32'(fwd_sel), 32'd0);
    check("nofwd_accept", 32'(issue_accept), 32'd1);
    check("nofwd_cnt", stall_cnt, 32'd4);
    forward_en = 1'b1;
    tick(); flush();

    // Register $0 and unused sources
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 3'd1); tick();
    drive(1'b1, 5'd0, 5'd0, 2'b11, 5'd9, 1'b0, 3'd1);
    check("r0_stall", 32'(stall), 32'd0);
    check("r0_fwd", 32'(fwd_sel), 32'd0);
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 3'd2); tick();
    drive(1'b1, 5'd1, 5'd6, 2'b01, 5'd9, 1'b1, 3'd1);
    check("unused_stall", 32'(stall), 32'd0);
    check("unused_fwd", 32'(fwd_sel), 32'd0);
    drive(1'b1, 5'd1, 5'd6, 2'b11, 5'd9, 1'b1, 3'd1);
    check("used_stall", 32'(stall), 32'd1);
    drive(1'b0, 5'd1, 5'd6, 2'b11, 5'd9, 1'b1, 3'd1);
    check("novalid_stall", 32'(stall), 32'd0);
    flush();

    // Kill: no combinational effect, clears the record at the edge
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 3'd1); tick();
    kill = 3'b001;
    drive(1'b1, 5'd9, 5'd0, 2'b01, 5'd11, 1'b1, 3'd1);
    check("kill_comb_fwd", 32'(fwd_sel), 32'h1);
    tick(); kill = '0;
    drive(1'b1, 5'd9, 5'd0, 2'b01, 5'd12, 1'b0, 3'd1);
    check("kill_stall", 32'(stall), 32'd0);
    check("kill_fwd", 32'(fwd_sel), 32'd0);
    tick(); flush();

    // Youngest match wins; identical sources resolve identically
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd12, 1'b1, 3'd1); tick();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd12, 1'b1, 3'd2); tick();
    drive(1'b1, 5'd12, 5'd12, 2'b11, 5'd1, 1'b1, 3'd1);
    check("young_stall", 32'(stall), 32'd1);
    check("young_fwd", 32'(fwd_sel), 32'd0);
    tick();
    check("young_stall2", 32'(stall), 32'd0);
    check("young_fwd2", 32'(fwd_sel), 32'ha);
    tick(); flush();

    // Latency beyond WB: never forwardable, read register file after retire
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd13, 1'b1, 3'd3); tick();
    drive(1'b1, 5'd13, 5'd0, 2'b01, 5'd1, 1'b1, 3'd1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("longlat_stall%0d", i), 32'(stall), 32'd1);
      tick();
    end
    check("longlat_stall3", 32'(stall), 32'd0);
    check("longlat_fwd", 32'(fwd_sel), 32'd0);
    check("longlat_cnt", stall_cnt, 32'd8);
    tick(); flush();

    // Mid-operation reset discards all records
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd14, 1'b1, 3'd1); tick();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd15, 1'b1, 3'd1); tick();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd16, 1'b1, 3'd1); tick();
    rst = 1'b1; idle(); tick(); rst = 1'b0;
    drive(1'b1, 5'd16, 5'd14, 2'b11, 5'd1, 1'b1, 3'd1);
    check("mrst_stall", 32'(stall), 32'd0);
    check("mrst_fwd", 32'(fwd_sel), 32'd0);
    check("mrst_cnt", stall_cnt, 32'd0);
    idle();

    // Counter saturation
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt_q;
    forward_en = 1'b0;
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd17, 1'b1, 3'd1); tick();
    drive(1'b1, 5'd17, 5'd0, 2'b01, 5'd1, 1'b1, 3'd1);
    check("sat_stall", 32'(stall), 32'd1);
    tick();
    check("sat_cnt1", stall_cnt, 32'hFFFF_FFFF);
    tick();
    check("sat_cnt2", stall_cnt, 32'hFFFF_FFFF);
    forward_en = 1'b1;
    flush();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
